// File: rtl/handshake_const_check.sv
// rtl/handshake_const_check.sv - elastic sink that checks data tokens against a constant and returns control tokens
//
// Purpose:
//   Consumes a data token, compares it with the compile-time value EXPECTED,
//   and hands a dataless control token downstream through one registered
//   slot. The return path is therefore cut by a register. Saturating
//   match/mismatch counters and a sticky mismatch flag are kept for debug.
//
// Parameters:
//   DATA_WIDTH    width of the input data token
//   EXPECTED      expected token value (low DATA_WIDTH bits used)
//   DROP_MISMATCH 0: forward a token per accepted input
//                 1: swallow mismatching inputs (accepted and counted only)
//   CNT_WIDTH     width of each statistics counter
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active high
//   ins            input data token
//   ins_valid      input token present
//   ins_ready      input accepted this cycle (combinational from outs_ready)
//   outs_valid     control token held in the output slot
//   outs_ready     downstream accepts the control token
//   mismatch       sticky flag, set by the first accepted mismatching token
//   match_count    accepted tokens equal to EXPECTED (saturating)
//   mismatch_count accepted tokens not equal to EXPECTED (saturating)
//   clear          synchronous clear of counters and flag; tokens unaffected

module handshake_const_check #(
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] EXPECTED      = 32'h07D9BBED,
  parameter int          DROP_MISMATCH = 0,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  input  logic                  clear
);

  // Slot occupancy encoding.
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  localparam logic [DATA_WIDTH-1:0] EXP_W   = DATA_WIDTH'(EXPECTED);
  localparam bit                    DROP    = (DROP_MISMATCH != 0);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  logic [0:0]           full_q,     full_d;
  logic                 mismatch_q, mismatch_d;
  logic [CNT_WIDTH-1:0] match_q,    match_d;
  logic [CNT_WIDTH-1:0] mism_q,     mism_d;

  logic acc;
  logic eq;
  logic fwd;
  logic drn;

  // The slot can take a new token while empty, or while its current token
  // leaves in the same cycle; this gives one token per cycle throughput.
  assign ins_ready = (full_q == S_EMPTY) || outs_ready;
  assign acc       = ins_valid && ins_ready;
  assign eq        = (ins == EXP_W);
  assign fwd       = acc && (eq || !DROP);
  assign drn       = (full_q == S_FULL) && outs_ready;

  // Slot next state: a forwarded token always lands in the slot (either
  // into an empty slot, or replacing one being drained); otherwise a drain
  // empties it and no drain holds it.
  always_comb begin
    full_d = full_q;
    if (fwd) begin
      full_d = S_FULL;
    end else if (drn) begin
      full_d = S_EMPTY;
    end
  end

  // Statistics: clear takes priority over counting a token accepted in the
  // same cycle, so that token is never counted.
  always_comb begin
    match_d    = match_q;
    mism_d     = mism_q;
    mismatch_d = mismatch_q;
    if (clear) begin
      match_d    = '0;
      mism_d     = '0;
      mismatch_d = 1'b0;
    end else if (acc) begin
      if (eq) begin
        if (match_q != CNT_MAX) begin
          match_d = match_q + CNT_ONE;
        end
      end else begin
        mismatch_d = 1'b1;
        if (mism_q != CNT_MAX) begin
          mism_d = mism_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= S_EMPTY;
      mismatch_q <= 1'b0;
      match_q    <= '0;
      mism_q     <= '0;
    end else begin
      full_q     <= full_d;
      mismatch_q <= mismatch_d;
      match_q    <= match_d;
      mism_q     <= mism_d;
    end
  end

  assign outs_valid     = (full_q == S_FULL);
  assign mismatch       = mismatch_q;
  assign match_count    = match_q;
  assign mismatch_count = mism_q;

endmodule

// File: tb/tb_handshake_const_check.sv
// tb/tb_handshake_const_check.sv - self-checking bench for handshake_const_check

module tb_handshake_const_check;

  localparam logic [31:0] EXP = 32'h07D9BBED;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        outs_ready = 1'b0;
  logic        clear = 1'b0;

  logic        ovalid [3];
  logic        irdy   [3];
  logic        mm     [3];
  logic [15:0] mc_w   [3];
  logic [15:0] mmc_w  [3];
  logic [3:0]  mc2, mmc2;

  always #5 clk = ~clk;

  // dut0: defaults; dut1: drops mismatches; dut2: 4-bit saturating counters.
  handshake_const_check u_dut0 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(irdy[0]),
    .outs_valid(ovalid[0]), .outs_ready(outs_ready), .mismatch(mm[0]),
    .match_count(mc_w[0]), .mismatch_count(mmc_w[0]), .clear(clear));

  handshake_const_check #(.DROP_MISMATCH(1)) u_dut1 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(irdy[1]),
    .outs_valid(ovalid[1]), .outs_ready(outs_ready), .mismatch(mm[1]),
    .match_count(mc_w[1]), .mismatch_count(mmc_w[1]), .clear(clear));

  handshake_const_check #(.CNT_WIDTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(irdy[2]),
    .outs_valid(ovalid[2]), .outs_ready(outs_ready), .mismatch(mm[2]),
    .match_count(mc2), .mismatch_count(mmc2), .clear(clear));

  assign mc_w[2]  = {12'b0, mc2};
  assign mmc_w[2] = {12'b0, mmc2};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: a token count in the slot plus integer statistics.
  bit model_init = 0;
  int m_occ [3];
  int m_mc  [3];
  int m_mmc [3];
  bit m_mm  [3];
  bit m_drop [3] = '{0, 1, 0};
  int m_max  [3] = '{65535, 65535, 15};

  task automatic drive(input bit r, input logic [31:0] d, input bit v,
                       input bit o, input bit c);
    @(negedge clk);
    rst = r; ins = d; ins_valid = v; outs_ready = o; clear = c;
    #1;
  endtask

  task automatic check_model();
    if (!model_init) return;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d_outs_valid", k), int'(ovalid[k]), (m_occ[k] > 0) ? 1 : 0);
      check($sformatf("d%0d_ins_ready", k), int'(irdy[k]),
            (m_occ[k] == 0 || outs_ready) ? 1 : 0);
      check($sformatf("d%0d_match_count", k), int'(mc_w[k]), m_mc[k]);
      check($sformatf("d%0d_mismatch_count", k), int'(mmc_w[k]), m_mmc[k]);
      check($sformatf("d%0d_mismatch", k), int'(mm[k]), int'(m_mm[k]));
    end
  endtask

  task automatic step_model();
    for (int k = 0; k < 3; k++) begin
      bit ready, accepted, equal;
      if (rst) begin
        m_occ[k] = 0; m_mc[k] = 0; m_mmc[k] = 0; m_mm[k] = 0;
        continue;
      end
      if (!model_init) continue;
      ready    = (m_occ[k] == 0) || outs_ready;
      accepted = ins_valid && ready;
      equal    = (ins == EXP);
      if (m_occ[k] > 0 && outs_ready) m_occ[k]--;
      if (accepted && (equal || !m_drop[k])) m_occ[k]++;
      if (clear) begin
        m_mc[k] = 0; m_mmc[k] = 0; m_mm[k] = 0;
      end else if (accepted) begin
        if (equal) m_mc[k] = (m_mc[k] + 1 > m_max[k]) ? m_max[k] : m_mc[k] + 1;
        else begin
          m_mmc[k] = (m_mmc[k] + 1 > m_max[k]) ? m_max[k] : m_mmc[k] + 1;
          m_mm[k]  = 1;
        end
      end
    end
    if (rst) model_init = 1;
  endtask

  task automatic cycle(input bit r, input logic [31:0] d, input bit v,
                       input bit o, input bit c);
    drive(r, d, v, o, c);
    check_model();
    step_model();
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] data;
    bit          vld;
    bit          ordy;
    bit          clr;
    bit          e_ov;
    bit          e_ir;
    int          e_mc;
    int          e_mmc;
    bit          e_mm;
    bit          e1_ov;
  } vec_t;

  vec_t vecs [22];

  initial begin
    //            rst data     vld ordy clr  ov ir mc mmc mm ov1
    vecs[0]  = '{0, EXP,      1, 1, 0,    0, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, EXP,      1, 1, 0,    1, 1, 1, 0, 0, 1};
    vecs[2]  = '{0, EXP,      1, 1, 0,    1, 1, 2, 0, 0, 1};
    vecs[3]  = '{0, EXP,      1, 1, 0,    1, 1, 3, 0, 0, 1};
    vecs[4]  = '{0, EXP,      0, 1, 0,    1, 1, 4, 0, 0, 1};
    vecs[5]  = '{0, EXP,      0, 1, 0,    0, 1, 4, 0, 0, 0};
    vecs[6]  = '{0, EXP,      1, 1, 0,    0, 1, 4, 0, 0, 0};
    vecs[7]  = '{0, 32'h1,    1, 1, 0,    1, 1, 5, 0, 0, 1};
    vecs[8]  = '{0, EXP,      1, 1, 0,    1, 1, 5, 1, 1, 0};
    vecs[9]  = '{0, 32'h0,    0, 1, 0,    1, 1, 6, 1, 1, 1};
    vecs[10] = '{0, 32'h0,    0, 1, 0,    0, 1, 6, 1, 1, 0};
    vecs[11] = '{0, EXP,      1, 0, 0,    0, 1, 6, 1, 1, 0};
    vecs[12] = '{0, EXP,      1, 0, 0,    1, 0, 7, 1, 1, 1};
    vecs[13] = '{0, EXP,      1, 0, 0,    1, 0, 7, 1, 1, 1};
    vecs[14] = '{0, EXP,      1, 1, 0,    1, 1, 7, 1, 1, 1};
    vecs[15] = '{0, EXP,      0, 1, 0,    1, 1, 8, 1, 1, 1};
    vecs[16] = '{0, EXP,      0, 1, 0,    0, 1, 8, 1, 1, 0};
    vecs[17] = '{0, EXP,      1, 1, 1,    0, 1, 8, 1, 1, 0};
    vecs[18] = '{0, EXP,      0, 1, 0,    1, 1, 0, 0, 0, 1};
    vecs[19] = '{0, EXP,      1, 0, 0,    0, 1, 0, 0, 0, 0};
    vecs[20] = '{1, EXP,      0, 0, 0,    1, 0, 1, 0, 0, 1};
    vecs[21] = '{0, EXP,      0, 0, 0,    0, 1, 0, 0, 0, 0};

    cycle(1, '0, 0, 1, 0);
    cycle(1, '0, 0, 1, 0);

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst, vecs[i].data, vecs[i].vld, vecs[i].ordy, vecs[i].clr);
      check_model();
      check($sformatf("vec%0d_outs_valid", i), int'(ovalid[0]), int'(vecs[i].e_ov));
      check($sformatf("vec%0d_ins_ready", i), int'(irdy[0]), int'(vecs[i].e_ir));
      check($sformatf("vec%0d_match_count", i), int'(mc_w[0]), vecs[i].e_mc);
      check($sformatf("vec%0d_mismatch_count", i), int'(mmc_w[0]), vecs[i].e_mmc);
      check($sformatf("vec%0d_mismatch", i), int'(mm[0]), int'(vecs[i].e_mm));
      check($sformatf("vec%0d_drop_outs_valid", i), int'(ovalid[1]), int'(vecs[i].e1_ov));
      step_model();
    end

    // 20 matching tokens: the 4-bit counter must stick at 15.
    for (int i = 0; i < 20; i++) cycle(0, EXP, 1, 1, 0);
    drive(0, EXP, 1, 1, 1);
    check_model();
    check("sat_match_count_w4", int'(mc_w[2]), 15);
    check("sat_match_count_w16", int'(mc_w[0]), 20);
    step_model();
    drive(0, EXP, 0, 1, 0);
    check_model();
    check("clear_match_count_w4", int'(mc_w[2]), 0);
    check("clear_token_forwarded", int'(ovalid[2]), 1);
    step_model();
    cycle(0, EXP, 0, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 1) == 0) ? EXP : $urandom;
      cycle(($urandom_range(0, 199) == 0), d, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/handshake_const_check.md
Name: handshake_const_check

Overview:
- Elastic-circuit sink-side counterpart to the constant generator. Consumes a data token, checks it against a compile-time expected value, and returns a dataless control token.
- Converts a data channel back into a control channel.
- Places one registered slot on the control output, so the return path is cut by a register.
- Keeps saturating match/mismatch counters and a sticky error flag for debug and self-checking designs.

Parameters:
- DATA_WIDTH, 32, width of the input data token.
- EXPECTED, 32'h07D9BBED, expected token value; only the low DATA_WIDTH bits are used.
- DROP_MISMATCH, 0:
  - 0: forward a control token for every accepted input.
  - 1: consume mismatching inputs without forwarding a token.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active high.
- ins  input  DATA_WIDTH  input data token.
- ins_valid  input  1  input token present.
- ins_ready  output  1  block accepts the input this cycle.
- outs_valid  output  1  control token present in the output slot.
- outs_ready  input  1  downstream accepts the control token.
- mismatch  output  1  sticky flag; set by the first accepted mismatching token.
- match_count  output  CNT_WIDTH  accepted tokens equal to EXPECTED.
- mismatch_count  output  CNT_WIDTH  accepted tokens not equal to EXPECTED.
- clear  input  1  synchronous clear of counters and the mismatch flag; tokens are unaffected.

Behaviour:
- Reset (rst=1 at a rising edge):
  - full=0, so outs_valid=0.
  - mismatch=0, match_count=0, mismatch_count=0.
  - Reset overrides all other inputs, including a handshake in the same cycle.
  - Mid-operation reset discards any held token.
- Slot state: a single bit, full. States are EMPTY (full=0) and FULL (full=1). outs_valid=full.
- ins_ready = !full || outs_ready (combinational from outs_ready only). Full throughput, one token per cycle.
- Accept event: acc = ins_valid && ins_ready.
- Compare: eq = (ins[DATA_WIDTH-1:0] == EXPECTED[DATA_WIDTH-1:0]). Evaluated only when acc=1; ins is ignored when ins_valid=0.
- Forward event: fwd = acc && (eq || !DROP_MISMATCH).
- Drain event: drn = full && outs_ready.
- Next-state table for full:
  - EMPTY, fwd → FULL. Latency from input accept to outs_valid is one cycle.
  - EMPTY, no fwd → EMPTY.
  - FULL, drn with fwd → FULL (simultaneous drain and refill).
  - FULL, drn without fwd → EMPTY.
  - FULL, no drn → FULL. ins_ready=0; input is stalled.
- Dropped token (DROP_MISMATCH=1, eq=0): still accepted (ins_ready rules unchanged) and counted; the slot is unchanged by that token.
- Counters, on each acc:
  - match_count += 1 if eq, otherwise mismatch_count += 1.
  - Both saturate at all-ones with no wrap.
- mismatch is set on acc && !eq and stays high until rst or clear.
- clear:
  - Counters and mismatch go to 0 the next cycle.
  - If acc occurs in the same cycle, clear wins for statistics: the token is not counted.
  - The token still flows normally through the slot.
- Valid stability: outs_valid, once high, stays high until drn. The block never withdraws a token.
- All outputs are registered except ins_ready.

Test Plan:
- Reset, then ins=0x07D9BBED with ins_valid held 4 cycles and outs_ready=1 → 4 accepts, outs_valid high cycles 2–5, match_count=4, mismatch=0.
- outs_ready=0 with a single matching token → outs_valid=1 and held; ins_ready=0; a second token stalls. Raise outs_ready → drain and refill in the same cycle, no loss or duplication.
- DROP_MISMATCH=0, inputs 0x07D9BBED, 0x00000001, 0x07D9BBED → 3 control tokens, match_count=2, mismatch_count=1, mismatch=1.
- DROP_MISMATCH=1, same sequence → 2 control tokens; the middle token is accepted with ins_ready=1 but produces no outs_valid; mismatch_count=1.
- CNT_WIDTH=4, 20 matching tokens → match_count saturates at 15. Pulse clear while acc=1 → counters=0 next cycle; that token is forwarded but not counted.
- rst asserted while full=1 and outs_ready=0 → next cycle outs_valid=0, all counters 0, ins_ready=1.
